// File: rtl/rv_div_unit.sv
// Iterative restoring integer divider for RV DIV/DIVU/REM/REMU, BITS_PER_CYCLE quotient bits per cycle.
// Optional RV_DIV_FAST_EN: divide-by-zero, signed overflow and MUL codes finish straight from IDLE.
module rv_div_unit #(
  parameter int XLEN           = 32,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out,
  output logic            busy
);

  localparam int ITER  = XLEN / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITER + 1);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]  ONE      = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]  ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [XLEN-1:0] neg2(input logic [XLEN-1:0] v);
    return ~v + ONE;
  endfunction

  state_t          state_r;
  state_t          state_s;
  logic            accept_s;
  logic            in_ready_r;
  logic            out_valid_r;
  logic            busy_r;
  logic [XLEN-1:0] result_r;
  logic [4:0]      rd_out_r;

  logic [2:0]      f3_r;
  logic [4:0]      rd_tag_r;
  logic            neg_q_r;
  logic            neg_r_r;
  logic [XLEN-1:0] dividend_r;
  logic [XLEN-1:0] divisor_r;
  logic [XLEN:0]   rem_r;
  logic [CNT_W-1:0] cnt_r;

  logic            signed_op_s;
  logic [XLEN-1:0] mag1_s;
  logic [XLEN-1:0] mag2_s;
  logic [XLEN:0]   rem_step_s;
  logic [XLEN-1:0] dvd_step_s;
  logic [XLEN-1:0] quot_fix_s;
  logic [XLEN-1:0] rem_fix_s;
  logic [XLEN-1:0] fix_res_s;

`ifdef RV_DIV_FAST_EN
  logic            corner_s;
  logic [XLEN-1:0] corner_res_s;

  // corner-case detection and direct result at accept time
  always_comb begin
    corner_s     = 1'b0;
    corner_res_s = ZERO;
    if (!funct3[2]) begin
      corner_s     = 1'b1;
      corner_res_s = ZERO;
    end else if (rs2 == ZERO) begin
      corner_s     = 1'b1;
      corner_res_s = funct3[1] ? rs1 : ONES;
    end else if (!funct3[0] && (rs1 == MIN_NEG) && (rs2 == ONES)) begin
      corner_s     = 1'b1;
      corner_res_s = funct3[1] ? ZERO : MIN_NEG;
    end else begin
      corner_s     = 1'b0;
      corner_res_s = ZERO;
    end
  end
`endif

  // next-state logic; flush overrides everything and masks an accept
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    if (flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready_r) begin
            accept_s = 1'b1;
`ifdef RV_DIV_FAST_EN
            state_s  = corner_s ? DONE : CALC;
`else
            state_s  = CALC;
`endif
          end else begin
            state_s = IDLE;
          end
        end
        CALC:    state_s = (cnt_r == LAST_CNT) ? FIXUP : CALC;
        FIXUP:   state_s = DONE;
        DONE:    state_s = out_ready ? IDLE : DONE;
        default: state_s = IDLE;
      endcase
    end
  end

  // state register and registered handshake flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  // operand magnitudes; unsigned ops pass raw values
  always_comb begin
    signed_op_s = ~funct3[0];
    mag1_s      = (signed_op_s && rs1[XLEN-1]) ? neg2(rs1) : rs1;
    mag2_s      = (signed_op_s && rs2[XLEN-1]) ? neg2(rs2) : rs2;
  end

  // BITS_PER_CYCLE restoring steps; quotient bits shift into the dividend register
  always_comb begin
    rem_step_s = rem_r;
    dvd_step_s = dividend_r;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      rem_step_s = {rem_step_s[XLEN-1:0], dvd_step_s[XLEN-1]};
      if (rem_step_s >= {1'b0, divisor_r}) begin
        rem_step_s = rem_step_s - {1'b0, divisor_r};
        dvd_step_s = {dvd_step_s[XLEN-2:0], 1'b1};
      end else begin
        dvd_step_s = {dvd_step_s[XLEN-2:0], 1'b0};
      end
    end
  end

  // sign fixup and quotient/remainder select
  always_comb begin
    quot_fix_s = neg_q_r ? neg2(dividend_r) : dividend_r;
    rem_fix_s  = neg_r_r ? neg2(rem_r[XLEN-1:0]) : rem_r[XLEN-1:0];
    if (!f3_r[2]) begin
      fix_res_s = ZERO;
    end else if (f3_r[1]) begin
      fix_res_s = rem_fix_s;
    end else begin
      fix_res_s = quot_fix_s;
    end
  end

  // datapath registers: operand capture, iteration, result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_r       <= 3'b000;
      rd_tag_r   <= 5'd0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      dividend_r <= ZERO;
      divisor_r  <= ZERO;
      rem_r      <= {(XLEN+1){1'b0}};
      cnt_r      <= CNT_ZERO;
      result_r   <= ZERO;
      rd_out_r   <= 5'd0;
    end else if (accept_s) begin
      f3_r       <= funct3;
      rd_tag_r   <= rd_in;
      neg_q_r    <= signed_op_s && (rs2 != ZERO) && (rs1[XLEN-1] ^ rs2[XLEN-1]);
      neg_r_r    <= signed_op_s && rs1[XLEN-1];
      dividend_r <= mag1_s;
      divisor_r  <= mag2_s;
      rem_r      <= {(XLEN+1){1'b0}};
      cnt_r      <= CNT_ZERO;
`ifdef RV_DIV_FAST_EN
      if (corner_s) begin
        result_r <= corner_res_s;
        rd_out_r <= rd_in;
      end
`endif
    end else if (!flush && (state_r == CALC)) begin
      rem_r      <= rem_step_s;
      dividend_r <= dvd_step_s;
      cnt_r      <= cnt_r + CNT_ONE;
    end else if (!flush && (state_r == FIXUP)) begin
      result_r   <= fix_res_s;
      rd_out_r   <= rd_tag_r;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign result    = result_r;
  assign rd_out    = rd_out_r;

endmodule

// File: tb/tb_rv_div_unit.sv
// Scoreboard bench for rv_div_unit (XLEN=32, BITS_PER_CYCLE=1); honours RV_DIV_FAST_EN for latency.
module tb_rv_div_unit;

  localparam int XLEN = 32;
  localparam int BPC  = 1;
  localparam int ITER = XLEN / BPC;
  localparam int LAT  = ITER + 2;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  funct3;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_err;
  int   n_chk;
  int   cyc;

  rv_div_unit #(.XLEN(XLEN), .BITS_PER_CYCLE(BPC)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .rd_in(rd_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rd_out(rd_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int sa;
    int sbv;
    logic ovf;
    sa  = a;
    sbv = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (!f3[2]) return 32'd0;
    case (f3[1:0])
      2'b00:   return (b == 32'd0) ? 32'hFFFF_FFFF : (ovf ? 32'h8000_0000 : 32'(sa / sbv));
      2'b01:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      2'b10:   return (b == 32'd0) ? a : (ovf ? 32'd0 : 32'(sa % sbv));
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef RV_DIV_FAST_EN
    if (!f3[2] || b == 32'd0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return LAT;
  endfunction

  // present one request for a cycle; push its expectation when it is meant to complete
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input bit push, output int t_acc);
    exp_t e;
    @(negedge clk);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    funct3 = f3; rs1 = a; rs2 = b; rd_in = rd; in_valid = 1'b1;
    t_acc = cyc;
    if (push) begin
      e.res = model(f3, a, b);
      e.rd  = rd;
      e.lat = exp_lat(f3, a, b);
      sb_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rs1 = $urandom; rs2 = $urandom; rd_in = 5'($urandom); funct3 = 3'($urandom);
  endtask

  // wait for out_valid, compare against scoreboard, optionally stall, then release
  task automatic collect(input int t_acc, input int hold);
    exp_t e;
    int   n;
    n = 0;
    while (!out_valid && n < ITER + 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check("timeout", 32'd0, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    check("result", result, e.res);
    check("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
    check("latency", 32'(cyc - t_acc), 32'(e.lat));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_result", result, e.res);
      check("hold_rd", {27'd0, rd_out}, {27'd0, e.rd});
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("hold_busy", {31'd0, busy}, 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    check("release_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input int hold);
    int t;
    issue(f3, a, b, rd, 1'b1, t);
    collect(t, hold);
  endtask

  // watch that an aborted op never raises out_valid
  task automatic expect_quiet(input string tag, input int cycles);
    int rises;
    rises = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (out_valid) rises++;
    end
    check(tag, 32'(rises), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    n_err = 0; n_chk = 0; cyc = 0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    funct3 = 3'b000; rs1 = 32'd0; rs2 = 32'd0; rd_in = 5'd0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_rd_out", {27'd0, rd_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run_op(3'b101, 32'd100, 32'd7, 5'd1, 0);
    run_op(3'b111, 32'd100, 32'd7, 5'd2, 0);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3, 0);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd4, 0);
    run_op(3'b100, 32'h1234_5678, 32'd0, 5'd5, 0);
    run_op(3'b101, 32'h1234_5678, 32'd0, 5'd6, 0);
    run_op(3'b110, 32'h1234_5678, 32'd0, 5'd7, 0);
    run_op(3'b111, 32'h1234_5678, 32'd0, 5'd8, 0);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
    run_op(3'b100, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 5'd12, 10);
    run_op(3'b000, 32'd55, 32'd5, 5'd13, 0);
    run_op(3'b011, 32'hDEAD_BEEF, 32'd3, 5'd14, 0);

    for (int i = 0; i < 8; i++) begin
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      a  = $urandom;
      b  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
      if (i == 3) b = 32'hFFFF_FFFE;
      run_op(f3, a, b, 5'($urandom), i % 3);
    end

    // flush in the middle of CALC discards the op
    issue(3'b101, 32'd1000, 32'd3, 5'd20, 1'b0, t);
    while (cyc < t + 12) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    check("flush_busy", {31'd0, busy}, 32'd0);
    expect_quiet("flush_no_valid", LAT + 4);
    run_op(3'b101, 32'd9, 32'd3, 5'd21, 0);

    // a request coinciding with flush must not be accepted
    @(negedge clk);
    funct3 = 3'b101; rs1 = 32'd50; rs2 = 32'd5; rd_in = 5'd22;
    in_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_busy", {31'd0, busy}, 32'd0);
    check("flush_accept_ready", {31'd0, in_ready}, 32'd1);
    expect_quiet("flush_accept_no_valid", LAT + 4);

    // asynchronous reset in the middle of CALC
    issue(3'b101, 32'd1000, 32'd3, 5'd23, 1'b0, t);
    while (cyc < t + 12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    expect_quiet("rst_no_valid", LAT + 4);
    run_op(3'b101, 32'd9, 32'd3, 5'd24, 0);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/rv_div_unit.md
Name: rv_div_unit

Overview:
- Iterative radix-2^k integer divider for the RV M extension: DIV, DIVU, REM and REMU.
- Sits beside the single-cycle multiplier in EX.
- Parametrised in operand width and quotient bits retired per cycle.
- Uses a valid/ready handshake so the pipeline can stall EX while it runs, and a flush input so branch/exception squash can abort it.

Parameters:
- XLEN, 32, operand/result width; must be a multiple of BITS_PER_CYCLE.
- BITS_PER_CYCLE, 1, quotient bits resolved per CALC cycle; legal values 1, 2, 4.
- ITER, XLEN/BITS_PER_CYCLE, derived localparam; number of CALC cycles.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  abort current op; synchronous
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept; high only in IDLE
- funct3  in  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
- rs1  in  XLEN  dividend
- rs2  in  XLEN  divisor
- rd_in  in  5  destination tag, carried through
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  XLEN  quotient or remainder
- rd_out  out  5  tag of the op that produced result
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, rd_out=0, busy=0, in_ready=1 once reset is released. All internal regs cleared.
- FSM states: IDLE, CALC, FIXUP, DONE.
- IDLE: on in_valid&&in_ready, latch funct3, rd_in, and the operand magnitudes.
  - Signed ops take |rs1|, |rs2|, unsigned ops take the raw values.
  - Record neg_q = sign(rs1)^sign(rs2), valid only for signed with rs2!=0.
  - Record neg_r = sign(rs1), signed only.
  - Clear partial remainder; iteration counter=0; go to CALC.
- CALC: restoring division, BITS_PER_CYCLE quotient bits per cycle, MSB first.
  - Each step: rem={rem,dividend msb}; if rem>=divisor then subtract and set q bit.
  - Partial remainder width is XLEN+1; no truncation.
  - Counter increments each cycle; after ITER cycles go to FIXUP.
- FIXUP: apply signs, then go to DONE.
  - Quotient: negate if neg_q.
  - Remainder: negate if neg_r.
  - Select quotient for funct3[1]=0, remainder for funct3[1]=1. Register into result.
- DONE: out_valid=1.
  - Hold result and rd_out stable until out_ready.
  - On out_valid&&out_ready go to IDLE; out_valid falls the next cycle.
  - No new request is accepted in the same cycle.
- Latency: accept at cycle T gives out_valid at T+ITER+2 (34 cycles for XLEN=32, BITS_PER_CYCLE=1).
- Throughput: one op per ITER+3 cycles minimum.
- RV corner results, produced naturally by the datapath rules above:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1. Quotient negation is suppressed when rs2==0.
  - Signed overflow (rs1=-2^(XLEN-1), rs2=-1): DIV gives -2^(XLEN-1); REM gives 0.
- funct3[2]=0 (MUL codes, not for this unit): accepted; result=0; normal latency.
- flush: highest priority except reset. In any state, the next state is IDLE and out_valid is 0 next cycle; the in-flight result is discarded. A request presented in the same cycle as flush is not accepted (in_ready is still high in IDLE, but flush masks the accept).
- Inputs are sampled only on accept; changes on rs1/rs2 during CALC have no effect.

Optional Feature:
- Macro: RV_DIV_FAST_EN.
- Defined: at accept, divide-by-zero, signed overflow and funct3[2]=0 bypass CALC and FIXUP.
  - The corner result is written directly and state goes to DONE.
  - out_valid is asserted at T+1.
- Not defined: all ops take ITER+2 cycles, with identical result values.

Test Plan:
- DIVU rs1=100, rs2=7 -> result=14, out_valid exactly 34 cycles after accept (XLEN=32, BITS_PER_CYCLE=1); REMU same operands -> 2.
- DIV rs1=-7 (0xFFFFFFF9), rs2=2 -> 0xFFFFFFFD (-3); REM same operands -> 0xFFFFFFFF (-1).
- DIV/DIVU/REM/REMU with rs1=0x12345678, rs2=0 -> 0xFFFFFFFF, 0xFFFFFFFF, 0x12345678, 0x12345678; with RV_DIV_FAST_EN, out_valid at T+1.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> 0x80000000; REM same operands -> 0; rd_out equals rd_in (e.g. 5'd10).
- Backpressure: out_ready held low 10 cycles after out_valid -> result/rd_out stable, in_ready=0, busy=1; one out_ready pulse -> IDLE next cycle.
- flush asserted mid-CALC (cycle 12), and separately rst_n pulsed low mid-CALC -> out_valid never rises for that op, in_ready=1 next cycle; a following DIVU 9/3 returns 3.
